// File: rtl/expmul_axil_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | expmul_axil_regs: AXI4-Lite register bank fronting the exp/multiply core.  |
// | Optional: EXPMUL_AXIL_IRQ_EN adds the IRQEN register (0x10) and o_irq.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module expmul_axil_regs #(
  parameter int C_ADDR_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [C_ADDR_W-1:0] i_awaddr,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [31:0]         i_wdata,
  input  logic [3:0]          i_wstrb,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [C_ADDR_W-1:0] i_araddr,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [31:0]         o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic                o_load,
  output logic                o_start,
  output logic                o_select,
  output logic [3:0]          o_A,
  output logic [3:0]          o_B,
  input  logic                i_done,
  input  logic [29:0]         i_P
`ifdef EXPMUL_AXIL_IRQ_EN
  ,
  output logic                o_irq
`endif
);

  localparam logic [C_ADDR_W-1:0] ADDR_CTRL    = C_ADDR_W'('h00);
  localparam logic [C_ADDR_W-1:0] ADDR_OPERAND = C_ADDR_W'('h04);
  localparam logic [C_ADDR_W-1:0] ADDR_STATUS  = C_ADDR_W'('h08);
  localparam logic [C_ADDR_W-1:0] ADDR_RESULT  = C_ADDR_W'('h0C);
`ifdef EXPMUL_AXIL_IRQ_EN
  localparam logic [C_ADDR_W-1:0] ADDR_IRQEN   = C_ADDR_W'('h10);
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rstate_t;

  wstate_t w_state_q, w_state_d;
  rstate_t r_state_q, r_state_d;

  logic        select_q, select_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic        done_q, done_d, busy_q, busy_d;
  logic [29:0] result_q, result_d;
  logic        load_q, load_d, start_q, start_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_s_q, done_dly_q;
`ifdef EXPMUL_AXIL_IRQ_EN
  logic        irqen_q, irqen_d, irq_q;
`endif

  logic [C_ADDR_W-1:0] waddr, raddr;
  logic        wr_en, w_mapped, r_mapped, done_rise;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign waddr     = {i_awaddr[C_ADDR_W-1:2], 2'b00};
  assign raddr     = {i_araddr[C_ADDR_W-1:2], 2'b00};
  assign wr_en     = (w_state_q == W_ACK) && i_wstrb[0];
  assign done_rise = done_s_q & ~done_dly_q;
  assign unused_ok = ^{i_awaddr[1:0], i_araddr[1:0], i_wstrb[3:1], i_wdata[31:8]};

  always_comb begin
    w_state_d = w_state_q;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: if (i_awvalid && i_wvalid) w_state_d = W_ACK;
      W_ACK: begin
        o_awready = 1'b1;
        o_wready  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    o_arready = 1'b0;
    o_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: if (i_arvalid) r_state_d = R_ACK;
      R_ACK: begin
        o_arready = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        o_rvalid = 1'b1;
        if (i_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word  = 32'd0;
    r_mapped = 1'b1;
    case (raddr)
      ADDR_CTRL:    rd_word = {30'd0, select_q, 1'b0};
      ADDR_OPERAND: rd_word = {24'd0, b_q, a_q};
      ADDR_STATUS:  rd_word = {30'd0, busy_q, done_q};
      ADDR_RESULT:  rd_word = {2'd0, result_q};
`ifdef EXPMUL_AXIL_IRQ_EN
      ADDR_IRQEN:   rd_word = {31'd0, irqen_q};
`endif
      default:      r_mapped = 1'b0;
    endcase
  end

  always_comb begin
    select_d = select_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = done_q;
    busy_d   = busy_q;
    result_d = result_q;
    load_d   = 1'b0;
    start_d  = 1'b0;
    bresp_d  = bresp_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    w_mapped = 1'b1;
`ifdef EXPMUL_AXIL_IRQ_EN
    irqen_d  = irqen_q;
`endif
    case (waddr)
      ADDR_CTRL: if (wr_en) begin
        select_d = i_wdata[1];
        start_d  = i_wdata[0] & ~busy_q;
      end
      ADDR_OPERAND: if (wr_en) begin
        a_d    = i_wdata[3:0];
        b_d    = i_wdata[7:4];
        load_d = 1'b1;
      end
      ADDR_STATUS: if (wr_en && i_wdata[0]) done_d = 1'b0;
      ADDR_RESULT: ;
`ifdef EXPMUL_AXIL_IRQ_EN
      ADDR_IRQEN: if (wr_en) irqen_d = i_wdata[0];
`endif
      default: w_mapped = 1'b0;
    endcase
    // Core completion overrides a coincident W1C so a fresh result is never lost.
    if (done_rise) begin
      result_d = i_P;
      done_d   = 1'b1;
      busy_d   = 1'b0;
    end
    if (start_d) busy_d = 1'b1;
    if (w_state_q == W_ACK) bresp_d = w_mapped ? RESP_OKAY : RESP_SLVERR;
    if (r_state_q == R_ACK) begin
      rdata_d = rd_word;
      rresp_d = r_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      select_q   <= 1'b0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= 30'd0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= 32'd0;
      rresp_q    <= RESP_OKAY;
      done_s_q   <= 1'b0;
      done_dly_q <= 1'b0;
`ifdef EXPMUL_AXIL_IRQ_EN
      irqen_q    <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      select_q   <= select_d;
      a_q        <= a_d;
      b_q        <= b_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      load_q     <= load_d;
      start_q    <= start_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      done_s_q   <= i_done;
      done_dly_q <= done_s_q;
`ifdef EXPMUL_AXIL_IRQ_EN
      irqen_q    <= irqen_d;
      irq_q      <= done_q & irqen_q;
`endif
    end
  end

  assign o_bresp  = bresp_q;
  assign o_rdata  = rdata_q;
  assign o_rresp  = rresp_q;
  assign o_load   = load_q;
  assign o_start  = start_q;
  assign o_select = select_q;
  assign o_A      = a_q;
  assign o_B      = b_q;
`ifdef EXPMUL_AXIL_IRQ_EN
  assign o_irq    = irq_q;
`endif

endmodule
`default_nettype wire
